uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised 16550-style UART receive path for the APB UART: divisor-driven oversampling baud
//  generator, RX frame FSM (5-8 data bits, none/odd/even/stick parity, 1/2 stop), per-char error
//  tagging and a configurable-depth RX FIFO with trigger level, overrun and char-timeout flags.
//  Sits between the RX pin and the register file (RBR/LSR/IIR logic consumes its outputs).
// PARAMETERS
//  FIFO_DEPTH   16  RX FIFO entries, power of 2, >=4
//  OVERSAMPLE   16  sample ticks per bit, even, >=8
//  DIV_W        16  divisor width (matches DLR)
//  SYNC_STAGES  2   RX input synchroniser flops
// PORTS
//  PCLK      in  1            system clock, all logic rising-edge
//  PRESETn   in  1            asynchronous active-low reset
//  divisor   in  DIV_W        PCLK cycles per sample tick; 0 treated as 1
//  wls       in  2            data bits = 5+wls (LCR[1:0])
//  stb       in  1            stop bits (LCR[2]); only first stop bit is checked
//  pen/eps/sp in 1 each       parity enable / even select / stick parity (LCR[5:3])
//  fifo_en   in  1            1: FIFO_DEPTH entries; 0: single holding register
//  rx_clr    in  1            1-cycle pulse: flush FIFO, clear timeout
//  trig_lvl  in  2            trigger 00=1, 01=D/4, 10=D/2, 11=D-2 entries (D=FIFO_DEPTH)
//  rx        in  1            serial input (async)
//  rd_en     in  1            pop head entry (ignored when empty)
//  lsr_rd    in  1            clears sticky oe
//  rd_data   out 8            head data, first-word-fall-through; upper unused bits 0
//  rd_err    out 3            head {BI,FE,PE}
//  level     out clog2(D)+1   occupancy
//  dr        out 1            level!=0
//  trig      out 1            level>=trigger
//  oe        out 1            sticky overrun
//  fifo_err  out 1            any stored entry has nonzero err
//  timeout   out 1            char timeout pending
// BEHAVIOUR
//  Reset: FSM=IDLE, counters 0, FIFO empty; rd_data=0, rd_err=0, level=0, dr/trig/oe/fifo_err/timeout=0.
//  Baud: div counter reloads at max(divisor,1)-1, emits 1-cycle tick; all FSM sampling on tick only.
//  FSM IDLE->START on synchronised rx 1->0; START: at tick OVERSAMPLE/2 rx=1 -> IDLE (false start),
//   else -> DATA. DATA: sample each bit at mid-bit (every OVERSAMPLE ticks), LSB first, 5+wls bits
//   -> PARITY if pen else STOP. PARITY: PE = received != expected (sp: expected = ~eps; else
//   even/odd over data). STOP: sample at mid-bit; FE=stop==0; push entry this cycle -> IDLE.
//  Break: data, parity and stop all 0 -> push single 0x00 with BI=1,FE=1 -> BRK_WAIT until rx=1 -> IDLE.
//  Stop bits beyond first not waited for; next start can be detected immediately after push.
//  Push latency: entry visible on rd_data/level the cycle after the stop-bit sample tick.
//  Full & push (no pop same cycle): char discarded, FIFO unchanged, oe<=1 until lsr_rd.
//  Push & pop same cycle: pop first; at full push succeeds, no oe; level unchanged.
//  lsr_rd and new overrun same cycle: oe stays 1. rx_clr with push same cycle: flush wins, char lost.
//  rx_clr does not abort an in-flight frame; fifo_en toggle acts as rx_clr.
//  Pointers wrap modulo FIFO_DEPTH; level saturates never (guarded by full check).
//  Timeout: counter of sample ticks reset on push, pop, rx_clr or level==0; timeout=1 when
//   count reaches 4*(1+5+wls+pen+1+stb)*OVERSAMPLE with level!=0; cleared by same events.
//  fifo_err: per-entry error bit vector OR-reduced; clears when errored entries popped/flushed.
//  PRESETn assertion mid-frame: immediate return to IDLE, FIFO emptied, partial char lost.
// STRUCTURE
//  Package uart_pkg: rx_state_e {IDLE,START,DATA,PARITY,STOP,BRK_WAIT}, err index localparams
//   (ERR_PE=0,ERR_FE=1,ERR_BI=2), trigger decode function, char_bits function.
//  Sub-module uart_sync_fifo (WIDTH=11, DEPTH param, FWFT, level/full/empty); FSM+baud in top.
// TESTING
//  divisor=13, 8N1, send 0xA5 -> rd_data=0xA5, rd_err=0, dr rises 1 cycle after stop sample.
//  7E2 send 0x35 with wrong parity -> rd_data=0x35, rd_err=3'b001; next 0x12 clean -> err 0.
//  rx low 3 tick-samples then high -> no push (false start); rx held low 2 char times -> one 0x00,
//   rd_err=3'b110, no further push until rx high.
//  D=16, send 17 chars no reads -> level=16, oe=1, char 17 lost; lsr_rd -> oe=0; read order 1..16.
//  trig_lvl=10, send 7 -> trig=0, 8th -> trig=1; send 1 then idle -> timeout at 4 char times, rd_en clears.
//  PRESETn pulse mid-DATA, then send 0x3C -> only 0x3C received, no error.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK_WAIT
  } rx_state_e;

  // Bit positions inside the 3-bit per-character error tag {BI,FE,PE}
  localparam int ERR_PE = 0;
  localparam int ERR_FE = 1;
  localparam int ERR_BI = 2;

  localparam int DATA_W  = 8;
  localparam int ERR_W   = 3;
  localparam int ENTRY_W = DATA_W + ERR_W;

  // FIFO entry as stored: error tag above the data byte
  typedef struct packed {
    logic [ERR_W-1:0]  err;
    logic [DATA_W-1:0] data;
  } rx_entry_t;

  // Trigger threshold in entries for the LCR/FCR trigger code
  function automatic int trig_decode(input logic [1:0] lvl, input int depth);
    case (lvl)
      2'b00:   return 1;
      2'b01:   return depth / 4;
      2'b10:   return depth / 2;
      default: return depth - 2;
    endcase
  endfunction

  // Bits in one character frame: start + data + parity + stop(s)
  function automatic logic [3:0] char_bits(input logic [1:0] wls, input logic pen,
                                           input logic stb);
    return 4'd7 + {2'b00, wls} + {3'b000, pen} + {3'b000, stb};
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side bus between the RX FIFO and the register file (RBR/LSR/IIR).
interface uart_rx_fifo_if #(parameter int FIFO_DEPTH = 16);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             rd_en;
  logic             lsr_rd;
  logic [7:0]       rd_data;
  logic [2:0]       rd_err;
  logic [LVL_W-1:0] level;
  logic             dr;
  logic             trig;
  logic             oe;
  logic             fifo_err;
  logic             timeout;

  // Register-file side
  modport master (
    output rd_en, lsr_rd,
    input  rd_data, rd_err, level, dr, trig, oe, fifo_err, timeout
  );

  // Receiver side
  modport slave (
    input  rd_en, lsr_rd,
    output rd_data, rd_err, level, dr, trig, oe, fifo_err, timeout
  );
endinterface

// File: rtl/uart_rx_fifo_sync.sv
// First-word-fall-through FIFO with occupancy, a one-deep mode and a per-entry tag bit.
module uart_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     single,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     wflag,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     drop,
  output logic                     any_flag
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [DEPTH-1:0] flags;
  logic             do_pop, do_push;

  assign empty    = (level == '0);
  assign full     = single ? !empty : (level == (AW+1)'(DEPTH));
  // Pop is taken first, so a push into a full FIFO with a same-cycle pop still lands
  assign do_pop   = pop && !empty && !flush;
  assign do_push  = push && (!full || do_pop) && !flush;
  assign drop     = push && full && !do_pop && !flush;
  assign rdata    = empty ? '0 : mem[rptr];
  assign any_flag = |flags;

  // Storage, no reset needed: reads are masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers, occupancy and tag bits; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      flags <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      flags <= '0;
    end else begin
      if (do_pop) begin
        rptr        <= rptr + AW'(1);
        flags[rptr] <= 1'b0;
      end
      if (do_push) begin
        wptr        <= wptr + AW'(1);
        flags[wptr] <= wflag;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// 16550-style receive path: baud tick, frame FSM, error tagging, RX FIFO and status flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [DIV_W-1:0] divisor,
  input  logic [1:0]       wls,
  input  logic             stb,
  input  logic             pen,
  input  logic             eps,
  input  logic             sp,
  input  logic             fifo_en,
  input  logic             rx_clr,
  input  logic [1:0]       trig_lvl,
  input  logic             rx,
  uart_rx_fifo_if.slave    rif
);
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int OS_W   = $clog2(OVERSAMPLE);
  localparam int TO_W   = $clog2(4 * 12 * OVERSAMPLE + 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_FULL = OS_W'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_s;
  logic [DIV_W-1:0]       div_cnt, div_max;
  logic                   tick;
  rx_state_e              state;
  logic [OS_W-1:0]        os_cnt;
  logic [2:0]             bit_idx, nbits_m1;
  logic [7:0]             shreg;
  logic                   par_bit, rx_last;
  logic                   push, is_break, exp_par, pe;
  rx_entry_t              wentry, head;
  logic                   flush, fifo_en_q, pop, drop, empty, full, any_err;
  logic [LVL_W-1:0]       level;
  logic [TO_W-1:0]        to_cnt, to_thr;
  logic                   to_rst;

  // Line idles high, so the synchroniser resets to 1
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) rx_sync <= '1;
    else          rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx};
  end
  assign rx_s = rx_sync[SYNC_STAGES-1];

  // Free-running sample-tick divider; divisor 0 behaves like 1
  assign div_max = (divisor == '0) ? '0 : divisor - DIV_W'(1);
  assign tick    = (div_cnt == '0);
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)  div_cnt <= '0;
    else if (tick) div_cnt <= div_max;
    else           div_cnt <= div_cnt - DIV_W'(1);
  end

  assign nbits_m1 = 3'd4 + {1'b0, wls};

  // Frame FSM; all line sampling happens on sample ticks
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      os_cnt  <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      rx_last <= 1'b1;
    end else if (tick) begin
      case (state)
        IDLE: begin
          rx_last <= rx_s;
          if (rx_last && !rx_s) begin
            state  <= START;
            os_cnt <= '0;
          end
        end
        START: begin
          if (os_cnt == OS_HALF) begin
            os_cnt <= '0;
            if (rx_s) begin
              state   <= IDLE;
              rx_last <= 1'b1;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
              shreg   <= '0;
            end
          end else os_cnt <= os_cnt + OS_W'(1);
        end
        DATA: begin
          if (os_cnt == OS_FULL) begin
            os_cnt         <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == nbits_m1) state <= pen ? PARITY : STOP;
            else                     bit_idx <= bit_idx + 3'd1;
          end else os_cnt <= os_cnt + OS_W'(1);
        end
        PARITY: begin
          if (os_cnt == OS_FULL) begin
            os_cnt  <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else os_cnt <= os_cnt + OS_W'(1);
        end
        STOP: begin
          // Only the first stop bit is checked; a new start may follow at once
          if (os_cnt == OS_FULL) begin
            os_cnt <= '0;
            if (is_break) state <= BRK_WAIT;
            else begin
              state   <= IDLE;
              rx_last <= rx_s;
            end
          end else os_cnt <= os_cnt + OS_W'(1);
        end
        BRK_WAIT: begin
          if (rx_s) begin
            state   <= IDLE;
            rx_last <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Character assembly at the stop-bit sample; the FIFO write lands on this edge
  always_comb begin
    push     = tick && (state == STOP) && (os_cnt == OS_FULL);
    is_break = (shreg == '0) && (!pen || !par_bit) && !rx_s;
    exp_par  = sp ? ~eps : (eps ? ^shreg : ~^shreg);
    pe       = pen && (par_bit != exp_par);
    wentry              = '0;
    wentry.data         = shreg;
    wentry.err[ERR_BI]  = is_break;
    wentry.err[ERR_FE]  = !rx_s;
    wentry.err[ERR_PE]  = pe && !is_break;
  end

  // Any change of fifo_en flushes just like rx_clr
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) fifo_en_q <= 1'b0;
    else          fifo_en_q <= fifo_en;
  end
  assign flush = rx_clr || (fifo_en != fifo_en_q);
  assign pop   = rif.rd_en && !empty;

  uart_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .flush    (flush),
    .single   (!fifo_en),
    .push     (push),
    .wdata    (wentry),
    .wflag    (|wentry.err),
    .pop      (rif.rd_en),
    .rdata    (head),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .drop     (drop),
    .any_flag (any_err)
  );

  // Sticky overrun; a new overrun beats a same-cycle LSR read
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)        rif.oe <= 1'b0;
    else if (drop)       rif.oe <= 1'b1;
    else if (rif.lsr_rd) rif.oe <= 1'b0;
  end

  // Character timeout: four frame times of sample ticks with no FIFO activity
  assign to_thr = TO_W'(char_bits(wls, pen, stb)) * TO_W'(4 * OVERSAMPLE);
  assign to_rst = push || pop || flush || empty;
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                    to_cnt <= '0;
    else if (to_rst)                 to_cnt <= '0;
    else if (tick && to_cnt < to_thr) to_cnt <= to_cnt + TO_W'(1);
  end

  assign rif.rd_data  = head.data;
  assign rif.rd_err   = head.err;
  assign rif.level    = level;
  assign rif.dr       = !empty;
  assign rif.trig     = int'(level) >= trig_decode(trig_lvl, FIFO_DEPTH);
  assign rif.fifo_err = any_err;
  assign rif.timeout  = (to_cnt >= to_thr) && !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table plus hand-written corner sequences.
module tb_uart_rx_fifo;
  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [15:0] divisor;
  logic [1:0]  wls, trig_lvl;
  logic        stb, pen, eps, sp, fifo_en, rx_clr, rx;

  uart_rx_fifo_if #(.FIFO_DEPTH(16)) rif();

  uart_rx_fifo #(.FIFO_DEPTH(16), .OVERSAMPLE(16), .DIV_W(16), .SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .divisor(divisor), .wls(wls), .stb(stb),
    .pen(pen), .eps(eps), .sp(sp), .fifo_en(fifo_en), .rx_clr(rx_clr),
    .trig_lvl(trig_lvl), .rx(rx), .rif(rif)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [15:0] div;
    logic [1:0]  w;
    logic        p, e, s, sb;
    logic [7:0]  d;
    logic        bad;
    logic [7:0]  xd;
    logic [2:0]  xe;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] e;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[9];
  int   n_chk = 0, n_fail = 0;
  logic dr_early, dr_late;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick_to(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // One complete frame; dr is captured a quarter and three quarters into the stop bit
  task automatic send(input logic [15:0] div, input logic [1:0] w, input logic p, e, s, sb,
                      input logic [7:0] d, input logic bad);
    int bc, nb;
    logic [7:0] dm;
    logic pb;
    bc = 16 * ((div == 0) ? 1 : int'(div));
    nb = 5 + int'(w);
    dm = d & (8'hFF >> (3 - int'(w)));
    pb = (s ? ~e : (e ? ^dm : ~^dm)) ^ bad;
    divisor = div; wls = w; pen = p; eps = e; sp = s; stb = sb;
    rx = 1'b0; tick_to(bc);
    for (int i = 0; i < nb; i++) begin rx = dm[i]; tick_to(bc); end
    if (p) begin rx = pb; tick_to(bc); end
    rx = 1'b1;
    repeat (bc / 4) @(posedge PCLK);
    @(negedge PCLK); dr_early = rif.dr;
    repeat (bc / 2) @(posedge PCLK);
    @(negedge PCLK); dr_late = rif.dr;
    tick_to(bc / 4);
    if (sb) tick_to(bc);
  endtask

  task automatic send81(input logic [7:0] d);
    send(16'd2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, d, 1'b0);
  endtask

  // Pop every expected entry, checking head data/err and the fifo_err summary
  task automatic drain(input string nm);
    exp_t x;
    logic any;
    int   k;
    while (exp_q.size() != 0) begin
      k = 0;
      @(negedge PCLK);
      while (!rif.dr && k < 20000) begin @(negedge PCLK); k++; end
      if (!rif.dr) begin
        chk({nm, "_dr_wait"}, 32'(rif.dr), 32'd1);
        exp_q.delete();
        return;
      end
      any = 1'b0;
      foreach (exp_q[i]) any |= (exp_q[i].e != 3'b000);
      x = exp_q.pop_front();
      chk({nm, "_data"},     32'(rif.rd_data),  32'(x.d));
      chk({nm, "_err"},      32'(rif.rd_err),   32'(x.e));
      chk({nm, "_fifo_err"}, 32'(rif.fifo_err), 32'(any));
      @(posedge PCLK); #1 rif.rd_en = 1'b1;
      @(posedge PCLK); #1 rif.rd_en = 1'b0;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'd2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 8'hA5, 3'b000};
    vecs[1] = '{16'd2, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'h35, 1'b1, 8'h35, 3'b001};
    vecs[2] = '{16'd2, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 8'h12, 3'b000};
    vecs[3] = '{16'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFB, 1'b0, 8'h1B, 3'b000};
    vecs[4] = '{16'd2, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h2A, 1'b0, 8'h2A, 3'b000};
    vecs[5] = '{16'd2, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h15, 1'b1, 8'h15, 3'b001};
    vecs[6] = '{16'd0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 8'hC3, 3'b000};
    vecs[7] = '{16'd1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h5A, 3'b000};
    vecs[8] = '{16'd3, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 8'h80, 3'b001};

    PRESETn = 1'b0; divisor = 16'd2; wls = 2'd3; stb = 1'b0; pen = 1'b0; eps = 1'b0;
    sp = 1'b0; fifo_en = 1'b1; rx_clr = 1'b0; trig_lvl = 2'b00; rx = 1'b1;
    rif.rd_en = 1'b0; rif.lsr_rd = 1'b0;
    tick_to(5);
    PRESETn = 1'b1;
    tick_to(5);

    // Reset state
    @(negedge PCLK);
    chk("rst_data", 32'(rif.rd_data), 0);  chk("rst_err", 32'(rif.rd_err), 0);
    chk("rst_level", 32'(rif.level), 0);   chk("rst_dr", 32'(rif.dr), 0);
    chk("rst_trig", 32'(rif.trig), 0);     chk("rst_oe", 32'(rif.oe), 0);
    chk("rst_fifo_err", 32'(rif.fifo_err), 0); chk("rst_timeout", 32'(rif.timeout), 0);

    // divisor 13, 8N1, 0xA5: dr rises near the stop-bit middle
    exp_q.push_back('{8'hA5, 3'b000});
    send(16'd13, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0);
    chk("a5_dr_early", 32'(dr_early), 0);
    chk("a5_dr_late", 32'(dr_late), 1);
    drain("a5");

    // Frame-format table
    foreach (vecs[i]) begin
      exp_q.push_back('{vecs[i].xd, vecs[i].xe});
      send(vecs[i].div, vecs[i].w, vecs[i].p, vecs[i].e, vecs[i].s, vecs[i].sb,
           vecs[i].d, vecs[i].bad);
      drain($sformatf("vec%0d", i));
    end

    // False start: 3 sample ticks low
    divisor = 16'd2; wls = 2'd3; pen = 1'b0; stb = 1'b0;
    rx = 1'b0; tick_to(6); rx = 1'b1; tick_to(640);
    @(negedge PCLK);
    chk("false_start_level", 32'(rif.level), 0);

    // Break: two frame times low -> exactly one 0x00 with BI|FE
    rx = 1'b0; tick_to(640);
    @(negedge PCLK);
    chk("brk_level_low", 32'(rif.level), 1);
    rx = 1'b1; tick_to(64);
    @(negedge PCLK);
    chk("brk_level_high", 32'(rif.level), 1);
    exp_q.push_back('{8'h00, 3'b110});
    drain("brk");
    exp_q.push_back('{8'h5A, 3'b000});
    send81(8'h5A);
    drain("post_brk");

    // Trigger at D/2 and overrun on the 17th character
    trig_lvl = 2'b10;
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) exp_q.push_back('{8'(i), 3'b000});
      send81(8'(i));
      @(negedge PCLK);
      if (i == 7)  begin chk("trig_7", 32'(rif.trig), 0); chk("lvl_7", 32'(rif.level), 7); end
      if (i == 8)  chk("trig_8", 32'(rif.trig), 1);
      if (i == 16) chk("oe_16", 32'(rif.oe), 0);
    end
    chk("ovr_level", 32'(rif.level), 16);
    chk("ovr_oe", 32'(rif.oe), 1);
    chk("ovr_head", 32'(rif.rd_data), 1);
    @(posedge PCLK); #1 rif.lsr_rd = 1'b1;
    @(posedge PCLK); #1 rif.lsr_rd = 1'b0;
    @(negedge PCLK);
    chk("oe_cleared", 32'(rif.oe), 0);
    drain("ovr");
    trig_lvl = 2'b00;

    // Character timeout after about four frame times of silence
    exp_q.push_back('{8'h99, 3'b000});
    send81(8'h99);
    tick_to(1150);
    @(negedge PCLK);
    chk("to_early", 32'(rif.timeout), 0);
    tick_to(200);
    @(negedge PCLK);
    chk("to_set", 32'(rif.timeout), 1);
    chk("to_trig", 32'(rif.trig), 1);
    drain("to");
    @(negedge PCLK);
    chk("to_cleared", 32'(rif.timeout), 0);

    // rx_clr flushes stored characters
    send81(8'h66);
    @(negedge PCLK);
    chk("clr_level_before", 32'(rif.level), 1);
    @(posedge PCLK); #1 rx_clr = 1'b1;
    @(posedge PCLK); #1 rx_clr = 1'b0;
    @(negedge PCLK);
    chk("clr_level", 32'(rif.level), 0);
    chk("clr_dr", 32'(rif.dr), 0);

    // Non-FIFO mode: one holding register, second char overruns
    fifo_en = 1'b0;
    tick_to(2);
    exp_q.push_back('{8'h41, 3'b000});
    send81(8'h41);
    send81(8'h42);
    @(negedge PCLK);
    chk("nf_level", 32'(rif.level), 1);
    chk("nf_oe", 32'(rif.oe), 1);
    @(posedge PCLK); #1 rif.lsr_rd = 1'b1;
    @(posedge PCLK); #1 rif.lsr_rd = 1'b0;
    drain("nf");
    fifo_en = 1'b1;
    tick_to(2);

    // Reset in the middle of a frame, with a stored char pending
    send81(8'h77);
    rx = 1'b0; tick_to(32);
    rx = 1'b0; tick_to(32);
    rx = 1'b0; tick_to(32);
    rx = 1'b1; tick_to(16);
    PRESETn = 1'b0;
    tick_to(3);
    @(negedge PCLK);
    chk("prst_level", 32'(rif.level), 0);
    chk("prst_dr", 32'(rif.dr), 0);
    PRESETn = 1'b1;
    rx = 1'b1; tick_to(64);
    exp_q.push_back('{8'h3C, 3'b000});
    send81(8'h3C);
    @(negedge PCLK);
    chk("prst_level_after", 32'(rif.level), 1);
    drain("prst");
    @(negedge PCLK);
    chk("final_level", 32'(rif.level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
